// File: rtl/apuf_pkg.sv
// Shared constants for the arbiter-PUF evaluation controller: FSM state
// encodings, default challenge width, LFSR taps and the LFSR step function.
package apuf_pkg;

    localparam int unsigned CHAL_W_DEFAULT = 243;
    localparam int unsigned LFSR_MAX_W     = 1023;
    localparam int unsigned STATE_W        = 3;

    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_SETUP  = 3'd1;
    localparam logic [STATE_W-1:0] ST_RISE   = 3'd2;
    localparam logic [STATE_W-1:0] ST_SAMPLE = 3'd3;
    localparam logic [STATE_W-1:0] ST_FALL   = 3'd4;
    localparam logic [STATE_W-1:0] ST_OUT    = 3'd5;

    // Taps counted down from the MSB (w-1, w-2, w-4) plus bit 0.
    localparam logic [9:0] TAP_MSB_A = 10'd1;
    localparam logic [9:0] TAP_MSB_B = 10'd2;
    localparam logic [9:0] TAP_MSB_C = 10'd4;
    localparam logic [9:0] TAP_LSB   = 10'd0;

    // One LFSR step on the low w bits of v (w >= 4); upper bits are cleared.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(input logic [LFSR_MAX_W-1:0] v,
                                                        input logic [9:0]            w);
        logic [LFSR_MAX_W-1:0] mask;
        logic                  fb;
        mask = (LFSR_MAX_W'(1) << w) - LFSR_MAX_W'(1);
        fb   = v[w - TAP_MSB_A] ^ v[w - TAP_MSB_B] ^ v[w - TAP_MSB_C] ^ v[TAP_LSB];
        lfsr_next = ((v << 1) | LFSR_MAX_W'(fb)) & mask;
    endfunction

endpackage

// File: rtl/apuf_sync2.sv
// Two-flop synchronizer bringing the asynchronous arbiter output into clk.
module apuf_sync2
    import apuf_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Double-register the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/apuf_eval_ctrl.sv
// Arbiter PUF evaluation controller: LFSR challenge generation, race launch,
// synchronized arbiter sampling and response-word packing.
// Optional majority voting per challenge: define APUF_MAJORITY_VOTE_EN.
module apuf_eval_ctrl
    import apuf_pkg::*;
#(
    parameter int unsigned CHAL_W = CHAL_W_DEFAULT,
    parameter int unsigned RESP_W = 32,
    parameter int unsigned SETTLE = 16,
    parameter int unsigned VOTES  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              seed_load,
    input  logic [CHAL_W-1:0] seed,
    output logic [CHAL_W-1:0] chal,
    output logic              launch_x,
    output logic              launch_y,
    input  logic              apuf_q,
    output logic              busy,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [RESP_W-1:0] resp_word
);

`ifdef APUF_MAJORITY_VOTE_EN
    localparam int unsigned NUM_EVAL = VOTES;
`else
    localparam int unsigned NUM_EVAL = 1;
`endif
    localparam int unsigned CNT_W  = $clog2(SETTLE);
    localparam int unsigned BIT_W  = (RESP_W > 1) ? $clog2(RESP_W) : 1;
    localparam int unsigned EVAL_W = $clog2(VOTES + 1);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [EVAL_W-1:0]  vote_cnt;
    logic               launch;
    logic               q_s;
    logic               settle_done;
    logic               last_vote;
    logic               last_bit;
    logic               bit_done;
    logic               bit_val;

    apuf_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (apuf_q),
        .q     (q_s)
    );

    assign launch_x    = launch;
    assign launch_y    = launch;
    assign settle_done = (cnt == CNT_W'(SETTLE - 1));
    assign last_vote   = (vote_cnt == EVAL_W'(NUM_EVAL - 1));
    assign last_bit    = (bit_cnt == BIT_W'(RESP_W - 1));
    assign bit_done    = (state == ST_FALL) && settle_done && last_vote;

`ifdef APUF_MAJORITY_VOTE_EN
    logic [EVAL_W-1:0] ones;

    // Tally of ones over the votes of the current challenge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones <= '0;
        end else if (state == ST_IDLE || bit_done) begin
            ones <= '0;
        end else if (state == ST_SAMPLE) begin
            ones <= ones + EVAL_W'(q_s);
        end
    end

    assign bit_val = (ones > EVAL_W'(VOTES / 2));
`else
    logic samp;

    // Single evaluation: hold the sampled arbiter value until the bit is written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp <= 1'b0;
        end else if (state == ST_SAMPLE) begin
            samp <= q_s;
        end
    end

    assign bit_val = samp;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_SETUP;
            ST_SETUP:  state_nxt = ST_RISE;
            ST_RISE:   if (settle_done) state_nxt = ST_SAMPLE;
            ST_SAMPLE: state_nxt = ST_FALL;
            ST_FALL: begin
                if (settle_done) begin
                    if (!last_vote)    state_nxt = ST_RISE;
                    else if (last_bit) state_nxt = ST_OUT;
                    else               state_nxt = ST_SETUP;
                end
            end
            ST_OUT:    if (resp_ready) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Counters, challenge LFSR, response packing and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            bit_cnt    <= '0;
            vote_cnt   <= '0;
            chal       <= CHAL_W'(1);
            launch     <= 1'b0;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            resp_word  <= '0;
        end else begin
            if (state_nxt != state) begin
                cnt <= '0;
            end else if (state == ST_RISE || state == ST_FALL) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (state == ST_IDLE) begin
                bit_cnt <= '0;
            end else if (bit_done && !last_bit) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end

            if (state == ST_IDLE) begin
                vote_cnt <= '0;
            end else if (state == ST_FALL && settle_done) begin
                vote_cnt <= last_vote ? '0 : vote_cnt + EVAL_W'(1);
            end

            // An all-zero seed would lock the LFSR, so it is replaced by 1.
            if (state == ST_IDLE && seed_load) begin
                chal <= (seed == '0) ? CHAL_W'(1) : seed;
            end else if (bit_done) begin
                chal <= CHAL_W'(lfsr_next(LFSR_MAX_W'(chal), 10'(CHAL_W)));
            end

            if (bit_done) begin
                resp_word[bit_cnt] <= bit_val;
            end

            launch     <= (state_nxt == ST_RISE);
            busy       <= (state_nxt != ST_IDLE);
            resp_valid <= (state_nxt == ST_OUT);
        end
    end

endmodule

// File: tb/tb_apuf_eval_ctrl.sv
// Self-checking bench for apuf_eval_ctrl with a timeline-based reference model.
module tb_apuf_eval_ctrl;

    localparam int CW = 243;
    localparam int RW = 8;
    localparam int ST = 4;
    localparam int VT = 5;
`ifdef APUF_MAJORITY_VOTE_EN
    localparam int NV      = VT;
    localparam int LAT_EXP = 368;
`else
    localparam int NV      = 1;
    localparam int LAT_EXP = 80;
`endif
    localparam int P = 1 + NV * (2 * ST + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          seed_load = 1'b0;
    logic [CW-1:0] seed = '0;
    logic          apuf_q = 1'b0;
    logic          resp_ready = 1'b0;
    logic [CW-1:0] chal;
    logic          launch_x;
    logic          launch_y;
    logic          busy;
    logic          resp_valid;
    logic [RW-1:0] resp_word;

    apuf_eval_ctrl #(.CHAL_W(CW), .RESP_W(RW), .SETTLE(ST), .VOTES(VT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .seed_load  (seed_load),
        .seed       (seed),
        .chal       (chal),
        .launch_x   (launch_x),
        .launch_y   (launch_y),
        .apuf_q     (apuf_q),
        .busy       (busy),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_word  (resp_word)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model state: position in the word timeline.
    int            mode = 0;
    logic          qtab [RW][5];
    logic [CW-1:0] m_chal;
    logic [RW-1:0] m_word;
    logic          m_act;
    logic          m_valid;
    int            m_bit;
    int            m_o;

    function automatic logic [CW-1:0] lfsr_m(input logic [CW-1:0] c);
        return {c[CW-2:0], c[CW-1] ^ c[CW-2] ^ c[CW-4] ^ c[0]};
    endfunction

    function automatic logic exp_bit(input int md, input logic [CW-1:0] c, input int b);
        int ones = 0;
        case (md)
            0: return 1'b1;
            1: return 1'b0;
            2: return ^c[7:0];
            default: begin
                for (int v = 0; v < NV; v++) ones += (qtab[b][v] ? 1 : 0);
                return ones > NV / 2;
            end
        endcase
    endfunction

    function automatic logic exp_launch();
        if (!m_act || m_o == 0) return 1'b0;
        return ((m_o - 1) % (2 * ST + 1)) < ST;
    endfunction

    function automatic logic [CW-1:0] rand_vec();
        logic [255:0] t;
        for (int k = 0; k < 8; k++) t[k*32 +: 32] = $urandom();
        return t[CW-1:0];
    endfunction

    // Compare process: check outputs, advance model, drive the arbiter output.
    initial begin
        int vidx;
        m_chal = CW'(1); m_word = '0; m_act = 1'b0; m_valid = 1'b0; m_bit = 0; m_o = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_chal = CW'(1); m_word = '0; m_act = 1'b0; m_valid = 1'b0; m_bit = 0; m_o = 0;
            end
            chk("chal", 256'(chal), 256'(m_chal));
            chk("launch_x", 256'(launch_x), 256'(exp_launch()));
            chk("launch_y", 256'(launch_y), 256'(exp_launch()));
            chk("busy", 256'(busy), 256'(m_act || m_valid));
            chk("resp_valid", 256'(resp_valid), 256'(m_valid));
            if (m_valid || !rst_n) chk("resp_word", 256'(resp_word), 256'(m_word));
            if (rst_n) begin
                if (m_valid) begin
                    if (resp_ready) m_valid = 1'b0;
                end else if (m_act) begin
                    m_o++;
                    if (m_o == P) begin
                        m_word[m_bit] = exp_bit(mode, m_chal, m_bit);
                        m_chal = lfsr_m(m_chal);
                        m_o = 0;
                        if (m_bit == RW - 1) begin
                            m_act = 1'b0;
                            m_valid = 1'b1;
                        end else begin
                            m_bit++;
                        end
                    end
                end else if (start) begin
                    m_act = 1'b1; m_bit = 0; m_o = 0;
                end else if (seed_load) begin
                    m_chal = (seed == '0) ? CW'(1) : seed;
                end
            end
            vidx = (m_o == 0) ? 0 : (m_o - 1) / (2 * ST + 1);
            case (mode)
                0:       apuf_q = 1'b1;
                1:       apuf_q = 1'b0;
                2:       apuf_q = ^m_chal[7:0];
                default: apuf_q = qtab[m_bit][vidx];
            endcase
        end
    end

    task automatic load_seed(input logic [CW-1:0] s);
        seed = s; seed_load = 1'b1;
        @(posedge clk); #1 seed_load = 1'b0;
    endtask

    task automatic run_word(input int md, input bit abuse, input int stall,
                            output logic [RW-1:0] w, output int lat);
        mode = md;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 5000) begin
            if (abuse) begin
                start = 1'($urandom_range(0, 1));
                seed_load = 1'($urandom_range(0, 1));
                seed = rand_vec();
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0; seed_load = 1'b0;
        chk("valid_seen", 256'(resp_valid), 256'(1));
        w = resp_word;
        for (int i = 0; i < stall; i++) begin
            start = abuse ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk); #1;
        end
        start = 1'b0;
        if (stall > 0) begin
            chk("hold_word", 256'(resp_word), 256'(w));
            chk("hold_valid", 256'(resp_valid), 256'(1));
            chk("hold_busy", 256'(busy), 256'(1));
        end
        resp_ready = 1'b1;
        @(posedge clk); #1 resp_ready = 1'b0;
        chk("post_hs_valid", 256'(resp_valid), 256'(0));
        chk("post_hs_busy", 256'(busy), 256'(0));
    endtask

    initial begin
        logic [RW-1:0] w;
        int            lat;
        int            n;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_chal", 256'(chal), 256'(1));
        chk("rst_launch", 256'(launch_x), 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_valid", 256'(resp_valid), 256'(0));
        chk("rst_word", 256'(resp_word), 256'(0));
        chk("model_lfsr_pin", 256'(lfsr_m(CW'(1))), 256'(3));

        load_seed(CW'(8'h5A));
        chk("seed_5a", 256'(chal), 256'(8'h5A));
        load_seed('0);
        chk("seed_zero", 256'(chal), 256'(1));

        run_word(0, 1'b0, 0, w, lat);
        chk("latency", 256'(lat), 256'(LAT_EXP));
        chk("word_ones", 256'(w), 256'(8'hFF));
        chk("chal_after_8", 256'(chal), 256'(12'h1FF));
        run_word(1, 1'b0, 0, w, lat);
        chk("word_zeros", 256'(w), 256'(8'h00));

        for (int i = 0; i < 3; i++) begin
            load_seed(rand_vec());
            run_word(2, 1'b0, $urandom_range(0, 6), w, lat);
        end

        for (int b = 0; b < RW; b++) begin
            qtab[b][0] = 1'b1; qtab[b][1] = 1'b0; qtab[b][2] = 1'b1; qtab[b][3] = 1'b1; qtab[b][4] = 1'b0;
        end
        run_word(3, 1'b0, 0, w, lat);
        chk("pattern_10110", 256'(w), 256'(8'hFF));
        for (int b = 0; b < RW; b++) begin
            qtab[b][0] = 1'b0; qtab[b][1] = 1'b0; qtab[b][2] = 1'b1; qtab[b][3] = 1'b0; qtab[b][4] = 1'b1;
        end
        run_word(3, 1'b0, 0, w, lat);
        chk("pattern_00101", 256'(w), 256'(8'h00));

        for (int i = 0; i < 4; i++) begin
            for (int b = 0; b < RW; b++)
                for (int v = 0; v < 5; v++) qtab[b][v] = 1'($urandom_range(0, 1));
            run_word(3, 1'b1, $urandom_range(0, 8), w, lat);
        end

        run_word(2, 1'b1, 50, w, lat);

        // Reset in the middle of bit 3, then a fresh word from chal=1.
        mode = 2;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        while (!(m_act && m_bit == 3 && m_o == 5) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("midword_busy", 256'(busy), 256'(1));
        rst_n = 1'b0;
        #1;
        chk("arst_chal", 256'(chal), 256'(1));
        chk("arst_launch", 256'(launch_y), 256'(0));
        chk("arst_busy", 256'(busy), 256'(0));
        chk("arst_valid", 256'(resp_valid), 256'(0));
        chk("arst_word", 256'(resp_word), 256'(0));
        @(posedge clk); #1 rst_n = 1'b1;
        run_word(2, 1'b0, 0, w, lat);
        chk("fresh_latency", 256'(lat), 256'(LAT_EXP));
        chk("fresh_parity_word", 256'(w), 256'(8'h55));

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/apuf_eval_ctrl.md
Name: apuf_eval_ctrl

Overview:
- Evaluation controller that sits directly upstream of the arbiter PUF chain and consumes its output.
- Generates challenge vectors with an internal LFSR and holds each challenge stable on the chain's select inputs.
- Launches the racing edge on the chain's two inputs, then samples the arbiter flip-flop output through a synchronizer.
- Packs one response bit per challenge into a RESP_W-bit word, delivered over a valid/ready handshake.

Parameters:
CHAL_W, 243, challenge width; equals the PUF stage count
RESP_W, 32, response bits packed per output word
SETTLE, 16, clock cycles each launch level is held (≥4; covers chain propagation plus arbiter settling)
VOTES, 5, evaluations per challenge when majority voting is compiled in (odd, ≥3)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins one response word (ignored unless IDLE)
seed_load  in  1  loads seed into the LFSR (accepted only in IDLE)
seed  in  CHAL_W  LFSR seed value
chal  out  CHAL_W  challenge to the chain select inputs
launch_x  out  1  race input X
launch_y  out  1  race input Y
apuf_q  in  1  arbiter flip-flop output (asynchronous to clk)
busy  out  1  high in any state other than IDLE
resp_valid  out  1  response word available
resp_ready  in  1  consumer accepts the word
resp_word  out  RESP_W  packed responses; first challenge in bit 0

Behaviour:
- Reset values: chal=1 (LFSR = 1), launch_x=launch_y=0, resp_valid=0, resp_word=0, busy=0, state IDLE, all counters 0.
- apuf_q passes through a 2-flop synchronizer (q_s); these flops also reset to 0.
- launch_x and launch_y are always driven from the same register, so they are identical in every cycle.
- LFSR update, applied once per finished challenge: shift left by one; bit0 <= chal[CHAL_W-1] ^ chal[CHAL_W-2] ^ chal[CHAL_W-4] ^ chal[0].
- seed_load in IDLE: chal <= seed. If seed is all-zero, chal <= 1 instead.
- FSM states:
  - IDLE: start moves to SETUP. bit_cnt=0, vote_cnt=0.
  - SETUP: 1 cycle; chal stable, launch low.
  - RISE: launch=1 for SETTLE cycles.
  - SAMPLE: 1 cycle; capture q_s into the current bit/vote.
  - FALL: launch=0 for SETTLE cycles, re-arming the arbiter.
  - After FALL:
    - If more votes remain, go to RISE.
    - Otherwise write the bit to resp_word[bit_cnt] and advance the LFSR.
    - If bit_cnt==RESP_W-1, go to OUT; else increment bit_cnt and go to SETUP.
  - OUT: resp_valid=1. When resp_valid&&resp_ready, go to IDLE next cycle and drop resp_valid.
- The challenge changes only on the SETUP entry edge. It never changes while launch=1.
- Cycles per challenge, single vote: 1+SETTLE+1+SETTLE (default 34). Per word: RESP_W×that (default 1088), plus OUT wait.
- resp_word holds its value while resp_valid is high. Stalled resp_ready holds state indefinitely; no data is lost.
- start during busy and seed_load outside IDLE are ignored.
- Asynchronous reset mid-operation returns all outputs to their reset values immediately. A partial word is discarded.

Optional Feature:
APUF_MAJORITY_VOTE_EN:
- Defined: each challenge runs RISE/SAMPLE/FALL VOTES times. A 0..VOTES counter tallies ones, and the bit is 1 iff ones > VOTES/2.
- Cycles per challenge: 1+VOTES×(2×SETTLE+1).
- Undefined: a single evaluation per challenge; the tally logic and VOTES are unused.

Decomposition:
- Package apuf_pkg holds:
  - the FSM state enum (IDLE, SETUP, RISE, SAMPLE, FALL, OUT)
  - CHAL_W_DEFAULT=243
  - the LFSR tap-index constants
  - an lfsr_next function
- One sub-module, apuf_sync2: the 2-flop synchronizer with async active-low reset.

Test Plan:
- Reset check: after reset, chal==1, launch low, resp_valid=0, busy=0. Then seed_load with seed=0 → chal==1.
- Single word, SETTLE=4, RESP_W=8, apuf_q tied 1 → resp_valid after 8×10 cycles; resp_word=8'hFF. The chal sequence matches the reference LFSR model for 8 steps. Repeat with apuf_q tied 0 → 8'h00.
- Behavioural model: apuf_q = parity of chal[7:0] → resp_word matches the model bit-for-bit, LSB first.
- Backpressure: hold resp_ready=0 for 50 cycles → resp_valid and resp_word stable, FSM stays in OUT. Release → one handshake, then IDLE.
- Abuse cases: start while busy, and seed_load while busy → no effect. Assert rst_n mid-word (bit 3) → immediate reset values; a new start produces a full fresh word.
- With APUF_MAJORITY_VOTE_EN, VOTES=5: apuf_q pattern 1,0,1,1,0 per challenge → bit=1. Pattern 0,0,1,0,1 → bit=0. Per-challenge cycle count is 46 at SETTLE=4.
